usbf_sram_arbiter: RTL and testbench



---
 rtl/usbf_sram_arbiter.sv | 70 +++++++
 tb/tb_usbf_sram_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/usbf_sram_arbiter.sv
// Buffer SSRAM arbiter between the USB protocol layer (m port) and the
// WISHBONE memory path (w port). The PL side has absolute priority and is
// acknowledged in the same cycle. The WISHBONE side uses idle slots only and
// gets a registered single-cycle ack.
module usbf_sram_arbiter #(
    parameter int SSRAM_HADR = 14
) (
    input  logic                  phy_clk,
    input  logic                  rst,

    // SSRAM pins
    output logic [SSRAM_HADR:0]   sram_adr,
    input  logic [31:0]           sram_din,
    output logic [31:0]           sram_dout,
    output logic                  sram_re,
    output logic                  sram_we,

    // Protocol layer port
    input  logic [SSRAM_HADR:0]   madr,
    output logic [31:0]           mdout,
    input  logic [31:0]           mdin,
    input  logic                  mwe,
    input  logic                  mreq,
    output logic                  mack,

    // WISHBONE port
    input  logic [SSRAM_HADR:0]   wadr,
    output logic [31:0]           wdout,
    input  logic [31:0]           wdin,
    input  logic                  wwe,
    input  logic                  wreq,
    output logic                  wack
);

    logic wsel;
    logic wack_p1;

    // W owns the SRAM while requesting and through its ack cycle, so the
    // address stays put long enough for read data to come back; any PL
    // request takes the SRAM immediately.
    assign wsel      = (wreq | wack_p1) & ~mreq;

    assign sram_adr  = wsel ? wadr : madr;
    assign sram_dout = wsel ? wdin : mdin;

    // Synchronous SRAM: always reading, data returns one cycle later.
    assign sram_re   = 1'b1;

    // A W write fires only in the cycle before wack, so it lands exactly once.
    assign sram_we   = (mreq & mwe) | (~mreq & wreq & wwe & ~wack_p1);

    // PL is never stalled.
    assign mack      = mreq;

    // Both requesters see the shared SRAM read bus.
    assign mdout     = sram_din;
    assign wdout     = sram_din;

    assign wack      = wack_p1;

    // ---- stage p1: WISHBONE ack, pulses one cycle after W wins an idle slot
    always_ff @(posedge phy_clk or negedge rst) begin
        if (!rst) begin
            wack_p1 <= 1'b0;
        end else begin
            wack_p1 <= wreq & ~mreq & ~wack_p1;
        end
    end

endmodule

// File: tb/tb_usbf_sram_arbiter.sv
// Directed bench for usbf_sram_arbiter with a behavioural synchronous SRAM,
// a reference memory of intended contents and a queue of expected read data.
module tb_usbf_sram_arbiter;

    localparam int HADR = 14;

    logic            phy_clk = 1'b0;
    logic            rst;
    logic [HADR:0]   sram_adr;
    logic [31:0]     sram_din;
    logic [31:0]     sram_dout;
    logic            sram_re;
    logic            sram_we;
    logic [HADR:0]   madr;
    logic [31:0]     mdout;
    logic [31:0]     mdin;
    logic            mwe;
    logic            mreq;
    logic            mack;
    logic [HADR:0]   wadr;
    logic [31:0]     wdout;
    logic [31:0]     wdin;
    logic            wwe;
    logic            wreq;
    logic            wack;

    int              errors = 0;
    int              checks = 0;
    int              wwr    = 0;
    int              wwr0;
    logic [31:0]     mem     [0:255];
    logic [31:0]     ref_mem [0:255];
    logic [31:0]     exp_q[$];
    logic [5:0]      pat;
    logic            got;

    usbf_sram_arbiter #(.SSRAM_HADR(HADR)) dut (
        .phy_clk   (phy_clk),
        .rst       (rst),
        .sram_adr  (sram_adr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .sram_re   (sram_re),
        .sram_we   (sram_we),
        .madr      (madr),
        .mdout     (mdout),
        .mdin      (mdin),
        .mwe       (mwe),
        .mreq      (mreq),
        .mack      (mack),
        .wadr      (wadr),
        .wdout     (wdout),
        .wdin      (wdin),
        .wwe       (wwe),
        .wreq      (wreq),
        .wack      (wack)
    );

    always #5 phy_clk = ~phy_clk;

    // Synchronous read-first SRAM model
    always @(posedge phy_clk) begin
        if (sram_we) mem[sram_adr[7:0]] <= sram_dout;
        sram_din <= mem[sram_adr[7:0]];
    end

    // Count SRAM writes that belong to the W port
    always @(posedge phy_clk) begin
        if (sram_we && !mreq) wwr <= wwr + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    initial begin
        rst = 1'b0; wreq = 1'b1; wwe = 1'b0; wadr = '0; wdin = '0;
        mreq = 1'b0; mwe = 1'b0; madr = '0; mdin = '0;

        // ---- reset held with wreq high
        @(negedge phy_clk); #1;
        chk("rst_wack", wack, 0);
        chk("rst_re", sram_re, 1);
        @(negedge phy_clk); rst = 1'b1; #1;
        chk("rel_wack0", wack, 0);
        @(negedge phy_clk); wreq = 1'b0; #1;
        chk("rel_wack1", wack, 1);
        @(negedge phy_clk); #1;
        chk("rel_wack2", wack, 0);

        // ---- PL write
        @(negedge phy_clk);
        mreq = 1'b1; mwe = 1'b1; madr = 15'h0010; mdin = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;
        #1;
        chk("mw_we", sram_we, 1);
        chk("mw_adr", sram_adr, 32'h0010);
        chk("mw_dout", sram_dout, 32'hDEADBEEF);
        chk("mw_mack", mack, 1);

        // ---- PL read of the same word
        @(negedge phy_clk); mwe = 1'b0; exp_q.push_back(ref_mem[8'h10]); #1;
        chk("mr_we", sram_we, 0);
        @(negedge phy_clk); mreq = 1'b0; #1;
        chk_pop("mr_data", mdout);
        chk("mr_mack0", mack, 0);

        // ---- WISHBONE write with PL idle
        wwr0 = wwr;
        @(negedge phy_clk);
        wreq = 1'b1; wwe = 1'b1; wadr = 15'h0020; wdin = 32'h12345678;
        ref_mem[8'h20] = 32'h12345678;
        #1;
        chk("ww_we", sram_we, 1);
        chk("ww_adr", sram_adr, 32'h0020);
        chk("ww_wack0", wack, 0);
        @(negedge phy_clk); #1;
        chk("ww_wack1", wack, 1);
        chk("ww_we_in_ack", sram_we, 0);
        @(negedge phy_clk); wreq = 1'b0; #1;
        chk("ww_wack2", wack, 0);
        chk("ww_count", wwr - wwr0, 1);

        // ---- WISHBONE read of the same word
        @(negedge phy_clk);
        wreq = 1'b1; wwe = 1'b0; wadr = 15'h0020;
        exp_q.push_back(ref_mem[8'h20]);
        #1;
        chk("wr_we", sram_we, 0);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge phy_clk); #1;
            if (wack) begin
                got = 1'b1;
                chk_pop("wr_data", wdout);
            end
        end
        chk("wr_timeout", got, 1);
        @(negedge phy_clk); wreq = 1'b0; #1;
        chk("wr_wack_end", wack, 0);

        // ---- collision: PL reads 0x10 while W wants to write 0x30
        wwr0 = wwr;
        @(negedge phy_clk);
        mreq = 1'b1; mwe = 1'b0; madr = 15'h0010;
        wreq = 1'b1; wwe = 1'b1; wadr = 15'h0030; wdin = 32'hA5A5A5A5;
        ref_mem[8'h30] = 32'hA5A5A5A5;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge phy_clk);
            #1;
            if (i > 0) chk_pop("col_mdout", mdout);
            exp_q.push_back(ref_mem[8'h10]);
            chk("col_adr", sram_adr, 32'h0010);
            chk("col_wack", wack, 0);
        end
        @(negedge phy_clk); mreq = 1'b0; #1;
        chk_pop("col_mdout_last", mdout);
        chk("col_wack_free", wack, 0);
        chk("col_we_free", sram_we, 1);
        chk("col_adr_free", sram_adr, 32'h0030);
        @(negedge phy_clk); #1;
        chk("col_wack1", wack, 1);
        @(negedge phy_clk); wreq = 1'b0; #1;
        chk("col_wack2", wack, 0);
        chk("col_wcount", wwr - wwr0, 1);

        // PL read confirms the deferred W write landed with the right data
        @(negedge phy_clk);
        mreq = 1'b1; mwe = 1'b0; madr = 15'h0030;
        exp_q.push_back(ref_mem[8'h30]);
        @(negedge phy_clk); mreq = 1'b0; #1;
        chk_pop("col_rdback", mdout);

        // ---- back-to-back W reads
        pat = 6'b101010;
        @(negedge phy_clk);
        wreq = 1'b1; wwe = 1'b0; wadr = 15'h0020;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge phy_clk);
            #1;
            chk($sformatf("b2b_wack%0d", i), wack, pat[i]);
        end
        @(negedge phy_clk); wreq = 1'b0;

        // ---- asynchronous reset during a wack pulse
        @(negedge phy_clk); #1;
        chk("ar_pre", wack, 0);
        @(negedge phy_clk); wreq = 1'b1;
        @(negedge phy_clk); #1;
        chk("ar_wack1", wack, 1);
        #2 rst = 1'b0; #1;
        chk("ar_clear", wack, 0);
        chk("ar_re", sram_re, 1);
        @(negedge phy_clk); rst = 1'b1; wreq = 1'b0; #1;
        chk("ar_after", wack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
